// File: rtl/branch_mispred_unit_pkg.sv
// rtl/branch_mispred_unit_pkg.sv - core definitions shared by the branch resolution path and the IFU
package branch_mispred_unit_pkg;

  typedef enum logic [1:0] {
    PC_PLUS_4      = 2'd0,
    SB_TYPE_ADDR   = 2'd1,
    UJ_TYPE_ADDR   = 2'd2,
    JALR_TYPE_ADDR = 2'd3
  } next_pc_t;

  localparam logic [1:0] BR_TYPE_SB   = 2'b00;
  localparam logic [1:0] BR_TYPE_UJ   = 2'b01;
  localparam logic [1:0] BR_TYPE_JALR = 2'b10;
  localparam logic [1:0] BR_TYPE_RSVD = 2'b11;

  // Wide enough for the largest legal hold load (FLUSH_CYCLES-1 = 14).
  localparam int HOLD_W = 4;

  // The reserved encoding resolves like a conditional branch.
  function automatic next_pc_t decode_target(input logic [1:0] br_type);
    next_pc_t sel;
    case (br_type)
      BR_TYPE_UJ:   sel = UJ_TYPE_ADDR;
      BR_TYPE_JALR: sel = JALR_TYPE_ADDR;
      BR_TYPE_SB,
      BR_TYPE_RSVD: sel = SB_TYPE_ADDR;
      default:      sel = SB_TYPE_ADDR;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/branch_mispred_unit_perf_counter.sv
// rtl/branch_mispred_unit_perf_counter.sv - wrapping event counter with synchronous clear
module perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= r_value + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign value = r_value;

endmodule

// File: rtl/branch_mispred_unit.sv
// rtl/branch_mispred_unit.sv - resolves branches against static not-taken prediction
// and drives flush, next-PC select and branch/misprediction counters.
module branch_mispred_unit
  import branch_mispred_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_branch_op,
  input  logic                 branch_taken,
  input  logic [1:0]           branch_type,
  output logic                 flush,
  output next_pc_t             next_pc_sel,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispred_count
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLUSH_CYCLES - 1);

  logic [HOLD_W-1:0] r_hold;
  logic              w_busy;
  logic              w_accept;
  logic              w_mispred;

  assign w_busy    = (r_hold != '0);
  // Resolutions seen during the hold window come from squashed younger instructions.
  assign w_accept  = is_branch_op & ~reset & ~w_busy;
  assign w_mispred = w_accept & branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= '0;
    end else if (w_mispred) begin
      r_hold <= HOLD_LOAD;
    end else if (w_busy) begin
      r_hold <= r_hold - {{(HOLD_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    next_pc_sel = PC_PLUS_4;
    if (w_mispred) begin
      next_pc_sel = decode_target(branch_type);
    end
  end

  assign flush = ~reset & (w_mispred | w_busy);
  assign busy  = w_busy;

  perf_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (clk),
    .inc   (w_accept),
    .clear (reset),
    .value (branch_count)
  );

  perf_counter #(.WIDTH(CNT_WIDTH)) u_mispred_cnt (
    .clk   (clk),
    .inc   (w_mispred),
    .clear (reset),
    .value (mispred_count)
  );

endmodule

// File: tb/tb_branch_mispred_unit.sv
// tb/tb_branch_mispred_unit.sv - directed scoreboard bench over three parameterisations
module tb_branch_mispred_unit;
  import branch_mispred_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // a: FLUSH_CYCLES=1, b: FLUSH_CYCLES=3, c: CNT_WIDTH=4
  logic a_rst, a_ib, a_bt; logic [1:0] a_ty;
  logic b_rst, b_ib, b_bt; logic [1:0] b_ty;
  logic c_rst, c_ib, c_bt; logic [1:0] c_ty;
  logic a_fl, b_fl, c_fl, a_bz, b_bz, c_bz;
  next_pc_t a_sel, b_sel, c_sel;
  logic [31:0] a_br, a_mp, b_br, b_mp;
  logic [3:0]  c_br, c_mp;

  branch_mispred_unit #(.FLUSH_CYCLES(1), .CNT_WIDTH(32)) u_a (
    .clk(clk), .reset(a_rst), .is_branch_op(a_ib), .branch_taken(a_bt), .branch_type(a_ty),
    .flush(a_fl), .next_pc_sel(a_sel), .busy(a_bz), .branch_count(a_br), .mispred_count(a_mp));
  branch_mispred_unit #(.FLUSH_CYCLES(3), .CNT_WIDTH(32)) u_b (
    .clk(clk), .reset(b_rst), .is_branch_op(b_ib), .branch_taken(b_bt), .branch_type(b_ty),
    .flush(b_fl), .next_pc_sel(b_sel), .busy(b_bz), .branch_count(b_br), .mispred_count(b_mp));
  branch_mispred_unit #(.FLUSH_CYCLES(1), .CNT_WIDTH(4)) u_c (
    .clk(clk), .reset(c_rst), .is_branch_op(c_ib), .branch_taken(c_bt), .branch_type(c_ty),
    .flush(c_fl), .next_pc_sel(c_sel), .busy(c_bz), .branch_count(c_br), .mispred_count(c_mp));

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    string tag;
    int    src;
    int    exp;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int src, input int exp);
    sb_entry_t e;
    e.tag = tag; e.src = src; e.exp = exp;
    sb_q.push_back(e);
  endtask

  function automatic int sb_obs(input int src);
    case (src)
      0: return int'(a_br);
      1: return int'(a_mp);
      2: return int'(b_br);
      3: return int'(b_mp);
      4: return int'(c_br);
      default: return int'(c_mp);
    endcase
  endfunction

  // Counters update on the edge, so expectations pushed with the stimulus are drained after it.
  task automatic tick_drain();
    sb_entry_t e;
    @(posedge clk); #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, sb_obs(e.src), e.exp);
    end
  endtask

  int exp_a_br = 0;
  int exp_a_mp = 0;
  int exp_c_br = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1; a_ib = 1; a_bt = 1; a_ty = 2'b01;
    b_rst = 1; b_ib = 1; b_bt = 1; b_ty = 2'b01;
    c_rst = 1; c_ib = 1; c_bt = 0; c_ty = 2'b00;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_flush_a", int'(a_fl), 0);
      chk("rst_sel_a", int'(a_sel), int'(PC_PLUS_4));
      chk("rst_flush_b", int'(b_fl), 0);
      @(posedge clk); #1;
    end
    a_rst = 0; a_ib = 0; b_rst = 0; b_ib = 0; c_rst = 0; c_ib = 0;
    chk("rst_a_br", int'(a_br), 0);
    chk("rst_a_mp", int'(a_mp), 0);
    chk("rst_b_br", int'(b_br), 0);
    chk("rst_b_busy", int'(b_bz), 0);
    chk("rst_c_br", int'(c_br), 0);

    // FLUSH_CYCLES=1: correct prediction, then three mispredictions back to back
    a_ib = 1; a_bt = 0; a_ty = 2'b00; #1;
    chk("nt_flush", int'(a_fl), 0);
    chk("nt_sel", int'(a_sel), int'(PC_PLUS_4));
    exp_a_br++;
    sb_push("nt_br", 0, exp_a_br); sb_push("nt_mp", 1, exp_a_mp);
    tick_drain();

    a_bt = 1; a_ty = 2'b01; #1;
    chk("jal_flush", int'(a_fl), 1);
    chk("jal_sel", int'(a_sel), int'(UJ_TYPE_ADDR));
    chk("jal_busy", int'(a_bz), 0);
    exp_a_br++; exp_a_mp++;
    sb_push("jal_br", 0, exp_a_br); sb_push("jal_mp", 1, exp_a_mp);
    tick_drain();

    a_ty = 2'b10; #1;
    chk("jalr_flush", int'(a_fl), 1);
    chk("jalr_sel", int'(a_sel), int'(JALR_TYPE_ADDR));
    chk("jalr_busy", int'(a_bz), 0);
    exp_a_br++; exp_a_mp++;
    sb_push("jalr_br", 0, exp_a_br); sb_push("jalr_mp", 1, exp_a_mp);
    tick_drain();

    a_ty = 2'b11; #1;
    chk("rsvd_flush", int'(a_fl), 1);
    chk("rsvd_sel", int'(a_sel), int'(SB_TYPE_ADDR));
    exp_a_br++; exp_a_mp++;
    sb_push("rsvd_br", 0, exp_a_br); sb_push("rsvd_mp", 1, 3);
    tick_drain();
    a_ib = 0; a_bt = 0; #1;
    chk("idle_flush_a", int'(a_fl), 0);

    // FLUSH_CYCLES=3: the two younger resolutions inside the window are dropped
    b_ib = 1; b_bt = 1; b_ty = 2'b00; #1;
    chk("h0_flush", int'(b_fl), 1);
    chk("h0_sel", int'(b_sel), int'(SB_TYPE_ADDR));
    chk("h0_busy", int'(b_bz), 0);
    sb_push("h0_br", 2, 1); sb_push("h0_mp", 3, 1);
    tick_drain();
    b_ty = 2'b01; #1;
    chk("h1_flush", int'(b_fl), 1);
    chk("h1_busy", int'(b_bz), 1);
    chk("h1_sel", int'(b_sel), int'(PC_PLUS_4));
    sb_push("h1_br", 2, 1); sb_push("h1_mp", 3, 1);
    tick_drain();
    b_ty = 2'b10; #1;
    chk("h2_flush", int'(b_fl), 1);
    chk("h2_busy", int'(b_bz), 1);
    chk("h2_sel", int'(b_sel), int'(PC_PLUS_4));
    sb_push("h2_br", 2, 1); sb_push("h2_mp", 3, 1);
    tick_drain();
    b_bt = 0; b_ty = 2'b00; #1;
    chk("h3_flush", int'(b_fl), 0);
    chk("h3_busy", int'(b_bz), 0);
    sb_push("h3_br", 2, 2); sb_push("h3_mp", 3, 1);
    tick_drain();

    // FLUSH_CYCLES=3: reset arriving mid-hold aborts the window
    b_bt = 1; b_ty = 2'b10; #1;
    chk("ra_flush", int'(b_fl), 1);
    chk("ra_sel", int'(b_sel), int'(JALR_TYPE_ADDR));
    sb_push("ra_br", 2, 3); sb_push("ra_mp", 3, 2);
    tick_drain();
    b_rst = 1; #1;
    chk("rb_flush", int'(b_fl), 0);
    chk("rb_sel", int'(b_sel), int'(PC_PLUS_4));
    sb_push("rb_br", 2, 0); sb_push("rb_mp", 3, 0);
    tick_drain();
    b_rst = 0; b_ib = 0; #1;
    chk("rc_busy", int'(b_bz), 0);
    chk("rc_flush", int'(b_fl), 0);
    tick_drain();
    chk("rd_busy", int'(b_bz), 0);

    // CNT_WIDTH=4: 17 correct resolutions wrap the branch counter to 1
    c_ib = 1; c_bt = 0;
    for (int i = 0; i < 17; i++) begin
      exp_c_br = (exp_c_br + 1) % 16;
      sb_push("wrap_br", 4, exp_c_br);
      tick_drain();
    end
    c_ib = 0;
    chk("wrap_final", int'(c_br), 1);
    chk("wrap_mp", int'(c_mp), 0);
    chk("wrap_busy", int'(c_bz), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_mispred_unit.md
# branch_mispred_unit

Resolves executed control-flow instructions against the front end's static not-taken prediction. It drives the pipeline `flush` and the fetch unit's next-PC select. It also keeps branch and misprediction performance counters. It sits between the functional-unit result path, which supplies the resolution, and the IFU/IDU/physical-register-file/RS flush inputs.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: total cycles `flush` stays high per misprediction; legal range 1..15.
- `CNT_WIDTH`, default 32: width of each performance counter.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high.
- `is_branch_op`, input, 1: a control-flow instruction resolves this cycle.
- `branch_taken`, input, 1: the resolved instruction redirects control flow.
- `branch_type`, input, 2: 00 = conditional (SB), 01 = JAL (UJ), 10 = JALR, 11 = treated as conditional.
- `flush`, output, 1: squash all speculative state in the front end and RS.
- `next_pc_sel`, output, `next_pc_t`: IFU next-PC mux select.
- `busy`, output, 1: flush-hold window active.
- `branch_count`, output, `CNT_WIDTH`: resolved control-flow instructions.
- `mispred_count`, output, `CNT_WIDTH`: mispredictions.

## Operation
- The prediction is always not-taken (PC+4). A resolution with `branch_taken=1` is a misprediction. A resolution with `branch_taken=0` is correct.
- A resolution is accepted when `is_branch_op=1`, `reset=0` and `busy=0`.
- Accepted misprediction, in the same cycle (combinational):
  - `flush=1`.
  - `next_pc_sel` = `SB_TYPE_ADDR`, `UJ_TYPE_ADDR` or `JALR_TYPE_ADDR` according to `branch_type`.
- Otherwise `next_pc_sel=PC_PLUS_4`.
- Flush hold: an accepted misprediction loads the hold counter with `FLUSH_CYCLES-1`. While the counter is nonzero:
  - `busy=1` and `flush=1`, and `next_pc_sel=PC_PLUS_4`.
  - The counter decrements each cycle.
  - Any `is_branch_op` is ignored: it belongs to a squashed younger instruction, so it is not counted and causes no redirect.
- With `FLUSH_CYCLES=1`, `flush` is a single-cycle combinational pulse and `busy` never asserts.
- Counters:
  - `branch_count` increments on every accepted resolution.
  - `mispred_count` increments on every accepted misprediction.
  - Both wrap modulo 2^`CNT_WIDTH`.
- While `reset=1`:
  - `flush=0`, `next_pc_sel=PC_PLUS_4`.
  - All inputs are ignored.
- Reset values after the first clock edge with `reset=1`:
  - `busy=0`, hold counter 0, `branch_count=0`, `mispred_count=0`.
- Reset asserted mid-hold aborts the hold at that edge. `flush` drops in the same cycle `reset` rises.

## Timing
- Resolution to `flush`/`next_pc_sel`: 0 cycles (combinational, no registers in the path). The IFU loads the redirect target on the next rising edge.
- Counter update: visible 1 cycle after the accepted resolution.
- Hold window: `flush` is high for exactly `FLUSH_CYCLES` consecutive cycles, starting in the resolution cycle.
- `busy` is high for the last `FLUSH_CYCLES-1` of those cycles.
- The first resolution accepted after a window is in the cycle after `busy` falls.
- Back-to-back resolutions with `FLUSH_CYCLES=1` are each accepted, one per cycle. Each mispredicted one produces its own flush cycle.

## Structure
- Shared package, in the existing core definitions package:
  - `typedef enum logic [1:0] next_pc_t {PC_PLUS_4=0, SB_TYPE_ADDR=1, UJ_TYPE_ADDR=2, JALR_TYPE_ADDR=3}`.
  - `branch_type` encodings as localparams.
- The IFU uses the same `next_pc_t`.
- Sub-module `perf_counter` (parameter `WIDTH`; ports: inc, clear, value) is instantiated twice.
- Hold logic and next-PC decode are local to this block.

## Test plan
- Reset for 2 cycles with `is_branch_op=1`, `branch_taken=1` → `flush=0`, `next_pc_sel=PC_PLUS_4`, both counters 0.
- `FLUSH_CYCLES=1`; drive `is_branch_op=1`, `branch_taken=0`, type 00 for 1 cycle → `flush=0`, `PC_PLUS_4`; next cycle `branch_count=1`, `mispred_count=0`.
- `FLUSH_CYCLES=1`; taken JAL (01) → same cycle `flush=1`, `next_pc_sel=UJ_TYPE_ADDR`; then JALR taken → `JALR_TYPE_ADDR`; then type 11 taken → `SB_TYPE_ADDR`; afterwards `mispred_count=3`.
- `FLUSH_CYCLES=3`; taken branch at cycle N, taken branches again at N+1 and N+2 → `flush` high N..N+2, `busy` high N+1..N+2, redirect only at N, `mispred_count=1`.
- `FLUSH_CYCLES=3`; taken branch, then `reset` at N+1 → `flush=0` at N+1, `busy=0` from N+2, counters 0.
- `CNT_WIDTH=4`; 17 non-taken resolutions → `branch_count=1` (wrap).
